// File: rtl/loader_reply_tx_if.sv
// Reply transmitter bus bundle: request handshake,
// block-memory read port and UART byte/lock port.
interface loader_reply_tx_if #(
  parameter int BITWIDTH = 16,
  parameter int WORDS    = 16
);
  logic                      req_valid;
  logic                      req_ready;
  logic [1:0]                req_type;
  logic [5:0]                req_status;
  logic [BITWIDTH-1:0]       req_addr;
  logic                      rd_req;
  logic [BITWIDTH-1:0]       rd_addr;
  logic                      rd_ack;
  logic [WORDS*BITWIDTH-1:0] rd_data;
  logic                      write_lock_req;
  logic                      write_lock_res;
  logic                      write_ready;
  logic [7:0]                data_in;
  logic                      data_in_valid;

  modport master (
    input  req_valid, req_type, req_status, req_addr,
    input  rd_ack, rd_data,
    input  write_lock_res, write_ready,
    output req_ready, rd_req, rd_addr,
    output write_lock_req, data_in, data_in_valid
  );

  modport slave (
    output req_valid, req_type, req_status, req_addr,
    output rd_ack, rd_data,
    output write_lock_res, write_ready,
    input  req_ready, rd_req, rd_addr,
    input  write_lock_req, data_in, data_in_valid
  );
endinterface

// File: rtl/loader_reply_tx.sv
// Loader reply framer: header, address, tile data over UART.
// Define REPLY_CHECKSUM_EN to append an XOR checksum byte.
module loader_reply_tx #(
  parameter int BITWIDTH = 16,
  parameter int WORDS    = 16
) (
  input  logic              clock,
  input  logic              reset,
  loader_reply_tx_if.master bus,
  output logic              busy
);
  localparam int BYTES  = BITWIDTH / 8;
  localparam int PBYTES = BYTES + WORDS * BYTES;
`ifdef REPLY_CHECKSUM_EN
  localparam int MAXLEN = 1 + PBYTES + 1;
`else
  localparam int MAXLEN = 1 + PBYTES;
`endif
  localparam int CW = $clog2(MAXLEN + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOCK, SEND, RELEASE
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0]                type_q;
  logic [5:0]                status_q;
  logic [BITWIDTH-1:0]       addr_q;
  logic [WORDS*BITWIDTH-1:0] tile_q;
  logic [CW-1:0]             idx_q;
  logic [CW-1:0]             idx_m1;
  logic [CW-1:0]             last_idx;
  logic [PBYTES*8-1:0]       payload;
  logic [PBYTES*8-1:0]       shifted;
  logic [7:0]                cur_byte;
  logic                      accept;
  logic                      take;
  logic                      fire;

  assign payload = {tile_q, addr_q};
  assign busy    = state_q != IDLE;

`ifdef REPLY_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       is_sum;
  assign is_sum = idx_q == last_idx;
`endif

  // Index of the final byte for the latched frame type.
  always_comb begin
    last_idx = '0;
    unique case (type_q)
      2'b01:   last_idx = CW'(BYTES);
      2'b10:   last_idx = CW'(PBYTES);
      default: last_idx = '0;
    endcase
`ifdef REPLY_CHECKSUM_EN
    last_idx = last_idx + 1'b1;
`endif
  end

  // Select the byte at the current frame position.
  always_comb begin
    idx_m1   = idx_q - 1'b1;
    shifted  = payload >> {idx_m1, 3'b000};
    cur_byte = shifted[7:0];
    unique case (1'b1)
      (idx_q == '0): cur_byte = {type_q, status_q};
`ifdef REPLY_CHECKSUM_EN
      is_sum:        cur_byte = csum_q;
`endif
      default: ;
    endcase
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d            = state_q;
    accept             = 1'b0;
    take               = 1'b0;
    fire               = 1'b0;
    bus.req_ready      = 1'b0;
    bus.rd_req         = 1'b0;
    bus.rd_addr        = '0;
    bus.write_lock_req = 1'b0;
    bus.data_in        = 8'h00;
    bus.data_in_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = !reset;
        accept        = bus.req_valid && !reset;
        if (accept)
          state_d = (bus.req_type == 2'b10) ? FETCH : LOCK;
      end
      FETCH: begin
        bus.rd_req  = 1'b1;
        bus.rd_addr = addr_q;
        take        = bus.rd_ack;
        if (take)
          state_d = LOCK;
      end
      LOCK: begin
        bus.write_lock_req = 1'b1;
        if (bus.write_lock_res)
          state_d = SEND;
      end
      SEND: begin
        bus.write_lock_req = 1'b1;
        bus.data_in        = cur_byte;
        fire = bus.write_lock_res
            && bus.write_ready && !reset;
        bus.data_in_valid  = fire;
        if (fire && idx_q == last_idx)
          state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request, captured tile and byte index.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      type_q   <= '0;
      status_q <= '0;
      addr_q   <= '0;
      tile_q   <= '0;
      idx_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        type_q   <= bus.req_type;
        status_q <= bus.req_status;
        addr_q   <= bus.req_addr;
      end
      if (take)
        tile_q <= bus.rd_data;
      if (state_q == LOCK)
        idx_q <= '0;
      else if (fire)
        idx_q <= idx_q + 1'b1;
    end
  end

`ifdef REPLY_CHECKSUM_EN
  // Running XOR of every byte already sent in this frame.
  always_ff @(posedge clock) begin
    if (reset || accept)
      csum_q <= 8'h00;
    else if (fire)
      csum_q <= csum_q ^ cur_byte;
  end
`endif
endmodule

// File: tb/tb_loader_reply_tx.sv
// Bench for loader_reply_tx: directed frames, stalls,
// mid-frame reset and randomized frames vs a byte model.
module tb_loader_reply_tx;
  localparam int BW = 16;
  localparam int WD = 4;
  localparam int BY = BW / 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;

  loader_reply_tx_if #(.BITWIDTH(BW), .WORDS(WD)) bus ();

  loader_reply_tx #(.BITWIDTH(BW), .WORDS(WD)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master),
    .busy (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int release_cycles = 0;
  bit rd_seen = 0;

  int lock_delay = 0;
  int lock_cnt = 0;
  int rd_delay = 0;
  int rd_cnt = 0;
  bit rdy_rand = 0;
  bit junk_ack = 0;
  bit stall_en = 0;
  bit stall_done = 0;
  int stall_t = -1;
  logic [BW-1:0] tile_w [WD];
  logic [BW-1:0] exp_rd_addr = '0;

  // Environment: lock arbiter, UART readiness, memory responder.
  always @(posedge clock) begin
    #1;
    if (bus.write_lock_req) lock_cnt++;
    else lock_cnt = 0;
    bus.write_lock_res = bus.write_lock_req && (lock_cnt > lock_delay);
    bus.write_ready = rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
    if (stall_t >= 0) begin
      stall_t++;
      if (stall_t == 7) begin
        stall_t = -1;
        stall_done = 1;
      end
    end
    if (stall_en && !stall_done && stall_t < 0 && got.size() == 3)
      stall_t = 0;
    if (stall_t >= 0) begin
      if (stall_t < 5) bus.write_ready = 1'b0;
      else bus.write_lock_res = 1'b0;
    end
    bus.rd_ack = 1'b0;
    if (bus.rd_req) begin
      rd_cnt++;
      if (rd_cnt > rd_delay) begin
        bus.rd_ack = 1'b1;
        for (int w = 0; w < WD; w++) bus.rd_data[w*BW +: BW] = tile_w[w];
      end
    end else begin
      rd_cnt = 0;
      if (junk_ack && $urandom_range(3) == 0) begin
        bus.rd_ack = 1'b1;
        bus.rd_data = {$urandom(), $urandom()};
      end
    end
  end

  // Monitor: collect accepted bytes, watch release and stalls.
  always @(negedge clock) begin
    if (!reset) begin
      if (stall_t >= 0) begin
        checks++;
        if (bus.data_in_valid !== 1'b0 || bus.data_in !== exp_q[got.size()]) begin
          errors++;
          $display("FAIL stall_hold: data_in %h valid %b required %h valid 0",
                   bus.data_in, bus.data_in_valid, exp_q[got.size()]);
        end
      end
      if (bus.data_in_valid) got.push_back(bus.data_in);
      if (busy && !bus.write_lock_req && got.size() > 0) release_cycles++;
      if (bus.rd_req) begin
        rd_seen = 1;
        checks++;
        if (bus.rd_addr !== exp_rd_addr) begin
          errors++;
          $display("FAIL rd_addr: got %h required %h", bus.rd_addr, exp_rd_addr);
        end
      end
    end
  end

  function automatic void build_exp(input logic [1:0] t, input logic [5:0] s,
                                    input logic [BW-1:0] a);
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back({t, s});
    if (t == 2'b01 || t == 2'b10)
      for (int i = 0; i < BY; i++) exp_q.push_back(8'((a >> (8 * i)) & 16'hff));
    if (t == 2'b10)
      for (int w = 0; w < WD; w++)
        for (int i = 0; i < BY; i++)
          exp_q.push_back(8'((tile_w[w] >> (8 * i)) & 16'hff));
`ifdef REPLY_CHECKSUM_EN
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
    exp_q.push_back(x);
`endif
  endfunction

  function automatic int first_diff();
    if (got.size() != exp_q.size()) return -2;
    foreach (got[i]) if (got[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic do_req(input logic [1:0] t, input logic [5:0] s,
                        input logic [BW-1:0] a);
    bit acc = 0;
    got.delete();
    release_cycles = 0;
    rd_seen = 0;
    exp_rd_addr = a;
    @(posedge clock);
    #2;
    bus.req_valid = 1'b1;
    bus.req_type = t;
    bus.req_status = s;
    bus.req_addr = a;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.req_ready) begin
        acc = 1;
        break;
      end
    end
    @(posedge clock);
    #2;
    bus.req_valid = 1'b0;
    bus.req_type = 2'($urandom);
    bus.req_status = 6'($urandom);
    bus.req_addr = BW'($urandom);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL req_accept: got ready 0 required 1");
    end
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock);
      #2;
      if (!busy) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL frame_timeout: got busy 1 required 0");
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 1'b0 || busy !== 1'b0 || bus.rd_req !== 1'b0 ||
        bus.write_lock_req !== 1'b0 || bus.data_in_valid !== 1'b0 ||
        bus.data_in !== 8'h00 || bus.rd_addr !== '0) begin
      errors++;
      $display("FAIL reset_cycle: got ready %b busy %b required all 0",
               bus.req_ready, busy);
    end
    @(posedge clock);
    #2;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got ready %b busy %b required 1 0",
               bus.req_ready, busy);
    end
  endtask

  task automatic test_ping();
    lock_delay = 3;
    exp_q = '{8'h2A};
`ifdef REPLY_CHECKSUM_EN
    exp_q.push_back(8'h2A);
`endif
    do_req(2'b00, 6'h2A, 16'h5555);
    wait_done();
    checks++;
    if (first_diff() != -1) begin
      errors++;
      $display("FAIL ping_bytes: got %p required %p", got, exp_q);
    end
    checks++;
    if (release_cycles != 1) begin
      errors++;
      $display("FAIL ping_release: got %0d cycles required 1", release_cycles);
    end
  endtask

  task automatic test_imem();
    lock_delay = 0;
    exp_q = '{8'h40, 8'h34, 8'h12};
`ifdef REPLY_CHECKSUM_EN
    exp_q.push_back(8'h66);
`endif
    do_req(2'b01, 6'h00, 16'h1234);
    wait_done();
    checks++;
    if (first_diff() != -1) begin
      errors++;
      $display("FAIL imem_bytes: got %p required %p", got, exp_q);
    end
    checks++;
    if (rd_seen) begin
      errors++;
      $display("FAIL imem_no_read: got rd_req 1 required 0");
    end
  endtask

  task automatic test_bmem(input bit stall, input string name);
    lock_delay = 1;
    rd_delay = 4;
    stall_en = stall;
    stall_done = 0;
    for (int w = 0; w < WD; w++) tile_w[w] = BW'(w + 1);
    exp_q = '{8'h80, 8'h10, 8'h00, 8'h01, 8'h00, 8'h02,
              8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
`ifdef REPLY_CHECKSUM_EN
    exp_q.push_back(8'h94);
`endif
    do_req(2'b10, 6'h00, 16'h0010);
    wait_done();
    stall_en = 0;
    checks++;
    if (first_diff() != -1) begin
      errors++;
      $display("FAIL %s_bytes: got %p required %p", name, got, exp_q);
    end
    checks++;
    if (!rd_seen || release_cycles != 1) begin
      errors++;
      $display("FAIL %s_seq: got read %b release %0d required 1 1",
               name, rd_seen, release_cycles);
    end
    if (stall) begin
      checks++;
      if (!stall_done) begin
        errors++;
        $display("FAIL stall_ran: got 0 required 1");
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    int bad = 0;
    lock_delay = 0;
    rd_delay = 2;
    for (int w = 0; w < WD; w++) tile_w[w] = BW'(16'hA0 + w);
    build_exp(2'b10, 6'h15, 16'hBEEF);
    do_req(2'b10, 6'h15, 16'hBEEF);
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #2;
      if (got.size() >= 5) begin
        hit = 1;
        break;
      end
    end
    reset = 1'b1;
    @(posedge clock);
    #3;
    checks++;
    if (!hit || bus.rd_req !== 1'b0 || bus.write_lock_req !== 1'b0 ||
        bus.data_in_valid !== 1'b0 || busy !== 1'b0 ||
        bus.data_in !== 8'h00 || bus.rd_addr !== '0 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got hit %b lock %b busy %b required 1 0 0",
               hit, bus.write_lock_req, busy);
    end
    for (int i = 0; i < 5 && i < got.size(); i++) if (got[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || got.size() < 5) begin
      errors++;
      $display("FAIL reset_prefix: got %p required prefix of %p", got, exp_q);
    end
    reset = 1'b0;
    lock_delay = 1;
    exp_q = '{8'h2A};
`ifdef REPLY_CHECKSUM_EN
    exp_q.push_back(8'h2A);
`endif
    do_req(2'b00, 6'h2A, 16'h0000);
    wait_done();
    checks++;
    if (first_diff() != -1) begin
      errors++;
      $display("FAIL reset_ping: got %p required %p", got, exp_q);
    end
  endtask

  task automatic test_random();
    logic [1:0] t;
    logic [5:0] s;
    logic [BW-1:0] a;
    rdy_rand = 1;
    junk_ack = 1;
    for (int n = 0; n < 30; n++) begin
      t = 2'($urandom);
      s = 6'($urandom);
      a = BW'($urandom);
      for (int w = 0; w < WD; w++) tile_w[w] = BW'($urandom);
      lock_delay = $urandom_range(4);
      rd_delay = $urandom_range(5);
      build_exp(t, s, a);
      do_req(t, s, a);
      wait_done();
      checks++;
      if (first_diff() != -1) begin
        errors++;
        $display("FAIL rand_bytes[%0d]: got %p required %p", n, got, exp_q);
      end
      checks++;
      if (rd_seen !== (t == 2'b10) || release_cycles != 1) begin
        errors++;
        $display("FAIL rand_seq[%0d]: got read %b release %0d required %b 1",
                 n, rd_seen, release_cycles, t == 2'b10);
      end
    end
    rdy_rand = 0;
    junk_ack = 0;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_type = 2'b00;
    bus.req_status = 6'h00;
    bus.req_addr = '0;
    bus.rd_ack = 1'b0;
    bus.rd_data = '0;
    bus.write_lock_res = 1'b0;
    bus.write_ready = 1'b1;
    for (int w = 0; w < WD; w++) tile_w[w] = '0;
    test_reset();
    test_ping();
    test_imem();
    test_bmem(1'b0, "bmem");
    test_bmem(1'b1, "stall");
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
